// File: rtl/dfr_readout_engine_if.sv
// rtl/dfr_readout_engine_if.sv - memory-side bus bundle (history, weight and result RAM ports) for the DFR readout engine
interface dfr_readout_engine_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] x_addr;
  logic [DATA_WIDTH-1:0] x_data;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [ADDR_WIDTH-1:0] z_addr;
  logic [DATA_WIDTH-1:0] z_data;
  logic                  z_wen;

  modport master (
    output x_addr, input x_data,
    output w_addr, input w_data,
    output z_addr, output z_data, output z_wen
  );

  modport slave (
    input x_addr, output x_data,
    input w_addr, output w_data,
    input z_addr, input z_data, input z_wen
  );
endinterface

// File: rtl/dfr_readout_engine.sv
// rtl/dfr_readout_engine.sv - multi-output fixed-point dot-product readout engine for the DFR core
// Optional bias row per output column is enabled by defining DFR_READOUT_BIAS_EN.
module dfr_readout_engine #(
  parameter int ADDR_WIDTH    = 14,
  parameter int DATA_WIDTH    = 32,
  parameter int FRAC_BITS     = 16,
  parameter int VIRTUAL_NODES = 10,
  parameter int NUM_OUTPUTS   = 4
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] num_samples,
  input  logic [ADDR_WIDTH-1:0] num_nodes,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           sat_count,
  dfr_readout_engine_if.master  mem
);

  localparam int ACC_W = 2 * DATA_WIDTH + $clog2(VIRTUAL_NODES) + 1;
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ONE_A  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] NO_A   = ADDR_WIDTH'(NUM_OUTPUTS);
  localparam logic [ADDR_WIDTH-1:0] K_LAST = ADDR_WIDTH'(NUM_OUTPUTS - 1);
  localparam logic [ADDR_WIDTH-1:0] VN_A   = ADDR_WIDTH'(VIRTUAL_NODES);
`ifdef DFR_READOUT_BIAS_EN
  localparam logic [ADDR_WIDTH-1:0] BIAS_READS = ADDR_WIDTH'(1);
`else
  localparam logic [ADDR_WIDTH-1:0] BIAS_READS = ADDR_WIDTH'(0);
`endif
  localparam logic signed [ACC_W-1:0] ROUND = ACC_W'(1) << (FRAC_BITS - 1);
  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, DONE} state_t;

  state_t state, next_state;

  logic [ADDR_WIDTH-1:0] samples_lat, nodes_lat;
  logic [ADDR_WIDTH-1:0] s_cnt, k_cnt, n_cnt;
  logic [1:0]            d_cnt;
  logic [ADDR_WIDTH-1:0] x_base, x_ptr, w_ptr, z_ptr;

  logic                  issuing, is_bias, write_now, last_dp;
  logic [ADDR_WIDTH-1:0] clamped_nodes, first_len, issue_len;

  logic                         v1, v2, v3, b1, b2;
  logic signed [DATA_WIDTH-1:0] xq, wq;
  logic signed [PROD_W-1:0]     prod;
  logic signed [ACC_W-1:0]      acc, rnd, shf;
  logic                         sat_hi, sat_lo, sat;
  logic [DATA_WIDTH-1:0]        result;

  assign clamped_nodes = (num_nodes > VN_A) ? VN_A : num_nodes;
  assign first_len     = clamped_nodes + BIAS_READS;
  assign issue_len     = nodes_lat + BIAS_READS;
  assign last_dp       = (k_cnt == K_LAST) && (s_cnt == samples_lat - ONE_A);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) state <= IDLE;
    else                state <= next_state;
  end

  always_comb begin
    next_state = state;
    issuing    = 1'b0;
    is_bias    = 1'b0;
    write_now  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        // A zero-length dot product has nothing to issue, so it starts straight in the flush.
        if (start && !abort)
          next_state = (num_samples == '0 || first_len != '0) ? ISSUE : DRAIN;
      end
      ISSUE: begin
        busy = 1'b1;
        if (samples_lat == '0) begin
          next_state = DONE;
        end else begin
          issuing = 1'b1;
          is_bias = (BIAS_READS != '0) && (n_cnt == nodes_lat);
          if (n_cnt == issue_len - ONE_A) next_state = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (d_cnt == 2'd2) next_state = WRITE;
      end
      WRITE: begin
        busy      = 1'b1;
        write_now = 1'b1;
        if (last_dp)                next_state = DONE;
        else if (issue_len == '0)   next_state = DRAIN;
        else                        next_state = ISSUE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (abort) next_state = IDLE;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      samples_lat <= '0;
      nodes_lat   <= '0;
      s_cnt       <= '0;
      k_cnt       <= '0;
      n_cnt       <= '0;
      d_cnt       <= '0;
      x_base      <= '0;
      x_ptr       <= '0;
      w_ptr       <= '0;
      z_ptr       <= '0;
      sat_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            samples_lat <= num_samples;
            nodes_lat   <= clamped_nodes;
            s_cnt       <= '0;
            k_cnt       <= '0;
            n_cnt       <= '0;
            d_cnt       <= '0;
            x_base      <= '0;
            x_ptr       <= '0;
            w_ptr       <= '0;
            z_ptr       <= '0;
            sat_count   <= '0;
          end
        end
        ISSUE: begin
          if (issuing) begin
            n_cnt <= n_cnt + ONE_A;
            w_ptr <= w_ptr + NO_A;
            if (!is_bias) x_ptr <= x_ptr + ONE_A;
          end
        end
        DRAIN: d_cnt <= (d_cnt == 2'd2) ? 2'd0 : d_cnt + 2'd1;
        WRITE: begin
          z_ptr <= z_ptr + ONE_A;
          n_cnt <= '0;
          if (sat && sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
          // Weight pointer restarts at the next column; history pointer only advances per sample.
          if (k_cnt == K_LAST) begin
            k_cnt  <= '0;
            s_cnt  <= s_cnt + ONE_A;
            x_base <= x_base + nodes_lat;
            x_ptr  <= x_base + nodes_lat;
            w_ptr  <= '0;
          end else begin
            k_cnt <= k_cnt + ONE_A;
            x_ptr <= x_base;
            w_ptr <= k_cnt + ONE_A;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
      b1 <= 1'b0; b2 <= 1'b0;
      xq <= '0; wq <= '0; prod <= '0; acc <= '0;
    end else if (abort || state == IDLE) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
      b1 <= 1'b0; b2 <= 1'b0;
      acc <= '0;
    end else begin
      v1 <= issuing;
      b1 <= is_bias;
      v2 <= v1;
      b2 <= b1;
      xq <= mem.x_data;
      wq <= mem.w_data;
      v3 <= v2;
      // The bias term behaves as a product with x = 1.0.
      prod <= b2 ? (PROD_W'(wq) <<< FRAC_BITS) : (PROD_W'(xq) * PROD_W'(wq));
      if (state == WRITE) acc <= '0;
      else if (v3)        acc <= acc + ACC_W'(prod);
    end
  end

  always_comb begin
    rnd    = acc + ROUND;
    shf    = rnd >>> FRAC_BITS;
    sat_hi = shf > MAX_V;
    sat_lo = shf < MIN_V;
    sat    = sat_hi || sat_lo;
    if (sat_hi)      result = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (sat_lo) result = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else             result = shf[DATA_WIDTH-1:0];
  end

  assign mem.x_addr = (issuing && !is_bias) ? x_ptr : '0;
  assign mem.w_addr = issuing ? w_ptr : '0;
  assign mem.z_addr = write_now ? z_ptr : '0;
  assign mem.z_data = write_now ? result : '0;
  assign mem.z_wen  = write_now;

endmodule
